// File: rtl/pind_input_port.sv
// Port D input block: two-flop synchronizer, per-pin debounce, stable PIND value,
// masked sticky pin-change flags and a single level interrupt toward the core.
module pind_input_port #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] PIND_pins_in,
  output logic [7:0] PIND_data_out,
  input  logic       PCMSK_write_en,
  input  logic [7:0] PCMSK_data_in,
  output logic [7:0] PCMSK_out,
  input  logic       PCIFR_clear_en,
  input  logic [7:0] PCIFR_clear_data,
  output logic [7:0] PCIFR_out,
  output logic       PCINT_irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1_r;
  logic [7:0]       sync2_r;
  logic [7:0]       stable_r;
  logic [CNT_W-1:0] cnt_r     [8];
  logic [7:0]       pcmsk_r;
  logic [7:0]       pcifr_r;

  logic [7:0]       stable_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s [8];
  logic [7:0]       accept_s;
  logic [7:0]       set_s;
  logic [7:0]       clr_s;
  logic [7:0]       pcifr_nxt_s;

  // Per-pin debounce: count consecutive mismatches against the stable level
  always_comb begin
    stable_nxt_s = stable_r;
    accept_s     = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (sync2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_MAX) begin
        stable_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i]    = '0;
        accept_s[i]     = 1'b1;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Flag next state: accepted edges gated by the pre-write mask; set beats clear
  always_comb begin
    set_s       = accept_s & pcmsk_r;
    clr_s       = {8{PCIFR_clear_en}} & PCIFR_clear_data;
    pcifr_nxt_s = set_s | (pcifr_r & ~clr_s);
  end

  // State registers with synchronous reset taking priority over all inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r  <= 8'h00;
      sync2_r  <= 8'h00;
      stable_r <= 8'h00;
      pcmsk_r  <= 8'h00;
      pcifr_r  <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r  <= PIND_pins_in;
      sync2_r  <= sync1_r;
      stable_r <= stable_nxt_s;
      pcifr_r  <= pcifr_nxt_s;
      if (PCMSK_write_en) begin
        pcmsk_r <= PCMSK_data_in;
      end else begin
        pcmsk_r <= pcmsk_r;
      end
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign PIND_data_out = stable_r;
  assign PCMSK_out     = pcmsk_r;
  assign PCIFR_out     = pcifr_r;
  assign PCINT_irq     = |pcifr_r;

endmodule

// File: tb/tb_pind_input_port.sv
// Directed and randomized bench for pind_input_port, checked every cycle against a
// sliding-window reference model of the debounce and flag rules.
module tb_pind_input_port;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pins = 8'h00;
  logic [7:0] pind;
  logic       mwe = 1'b0;
  logic [7:0] md = 8'h00;
  logic [7:0] msk;
  logic       clr_en = 1'b0;
  logic [7:0] clr_data = 8'h00;
  logic [7:0] flg;
  logic       irq;

  int total = 0;
  int bad   = 0;

  // Reference model state: pipeline, last samples per pin, stable, mask, flags
  bit [7:0]  m_p1, m_p2, m_stab, m_msk, m_flg;
  bit [15:0] m_hist [8];

  pind_input_port #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .PIND_pins_in(pins), .PIND_data_out(pind),
    .PCMSK_write_en(mwe), .PCMSK_data_in(md), .PCMSK_out(msk),
    .PCIFR_clear_en(clr_en), .PCIFR_clear_data(clr_data), .PCIFR_out(flg),
    .PCINT_irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A pin accepts a new level once its last D synchronized samples all differ from stable
  task automatic model_update();
    bit [7:0] acc;
    bit       all_diff;
    acc = 8'h00;
    if (reset) begin
      m_p1 = 8'h00; m_p2 = 8'h00; m_stab = 8'h00; m_msk = 8'h00; m_flg = 8'h00;
      for (int i = 0; i < 8; i++) m_hist[i] = 16'h0000;
    end else begin
      for (int i = 0; i < 8; i++) begin
        m_hist[i] = {m_hist[i][14:0], m_p2[i]};
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (m_hist[i][k] == m_stab[i]) all_diff = 1'b0;
        acc[i] = all_diff;
      end
      m_stab = m_stab ^ acc;
      m_flg  = (acc & m_msk) | (m_flg & ~(clr_en ? clr_data : 8'h00));
      if (mwe) m_msk = md;
      m_p2 = m_p1;
      m_p1 = pins;
    end
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      model_update();
      #1;
      chk8("pind", pind, m_stab);
      chk8("pcmsk", msk, m_msk);
      chk8("pcifr", flg, m_flg);
      chk8("irq", {7'd0, irq}, {7'd0, |m_flg});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mwe = 1'b0; clr_en = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mwe = 1'b1; md = v;
    step(1);
    mwe = 1'b0;
  endtask

  initial begin
    // 1: reset with pins high, stable appears at the 6th edge after release
    pins = 8'hFF;
    step(2);
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      chk8("t1_low", pind, 8'h00);
    end
    step(1);
    chk8("t1_high", pind, 8'hFF);
    chk8("t1_flags", flg, 8'h00);

    // 2: masked rising edge on pin0, then W1C clear
    pins = 8'h00; do_reset(); write_mask(8'h01); step(2);
    pins = 8'h01;
    step(5);
    chk8("t2_pre_pind", pind, 8'h00);
    chk8("t2_pre_flag", flg, 8'h00);
    step(1);
    chk8("t2_pind", pind, 8'h01);
    chk8("t2_flag", flg, 8'h01);
    chk8("t2_irq", {7'd0, irq}, 8'h01);
    step(3);
    clr_en = 1'b1; clr_data = 8'h01;
    step(1);
    clr_en = 1'b0;
    chk8("t2_clr_flag", flg, 8'h00);
    chk8("t2_clr_irq", {7'd0, irq}, 8'h00);

    // 3: 5-clock pulse accepted, 3-clock pulse rejected
    pins = 8'h00; do_reset(); write_mask(8'h01); step(2);
    pins = 8'h01; step(5); pins = 8'h00; step(1);
    chk8("t3_long_pind", pind, 8'h01);
    chk8("t3_long_flag", flg, 8'h01);
    do_reset(); write_mask(8'h01); step(2);
    pins = 8'h01; step(3); pins = 8'h00; step(8);
    chk8("t3_short_pind", pind, 8'h00);
    chk8("t3_short_flag", flg, 8'h00);

    // 4: set and clear on the same bit in the same cycle, set wins
    do_reset(); write_mask(8'hFF); step(2);
    pins = 8'h08; step(5);
    clr_en = 1'b1; clr_data = 8'h08;
    step(1);
    clr_en = 1'b0;
    chk8("t4_setwins", flg, 8'h08);

    // 5: accept coincides with mask write, old mask gates it
    pins = 8'h00; do_reset(); step(2);
    pins = 8'h20; step(5);
    mwe = 1'b1; md = 8'h20;
    step(1);
    mwe = 1'b0;
    chk8("t5_flag", flg, 8'h00);
    chk8("t5_mask", msk, 8'h20);
    chk8("t5_pind", pind, 8'h20);
    pins = 8'h00; step(6);
    chk8("t5_fall_flag", flg, 8'h20);

    // 6: reset one cycle before pin7 accepts, latency restarts
    do_reset(); write_mask(8'hFF); step(2);
    pins = 8'h80; step(5);
    reset = 1'b1; step(1);
    chk8("t6_pind", pind, 8'h00);
    chk8("t6_mask", msk, 8'h00);
    chk8("t6_flag", flg, 8'h00);
    reset = 1'b0;
    step(5);
    chk8("t6_restart_low", pind, 8'h00);
    step(1);
    chk8("t6_restart_high", pind, 8'h80);

    // Randomized traffic: held levels with glitches, mask writes, clears, rare resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(5, 0) == 0) pins = 8'($urandom());
      mwe = ($urandom_range(9, 0) == 0);
      md = 8'($urandom());
      clr_en = ($urandom_range(7, 0) == 0);
      clr_data = 8'($urandom());
      reset = ($urandom_range(199, 0) == 0);
      step(1);
    end
    reset = 1'b0; mwe = 1'b0; clr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pind_input_port.md
# pind_input_port

Input-direction companion to the Port D output register. Samples eight asynchronous external pins, synchronizes and debounces them, and presents a stable `PIND` value to the RISC-V Arduino memory-mapped bus. Detects per-pin changes into a sticky pin-change flag register, gated by a writable pin-change mask, and raises one level interrupt toward the core.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-sample mismatches needed to accept a new pin level. Legal range is 1..255.
- `CNT_W`, default 8: width of each per-pin debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clock` in 1: single system clock. All state is updated on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `PIND_pins_in` in 8: raw external pins. Asynchronous to `clock`.
- `PIND_data_out` out 8: debounced stable pin levels (the `PIND` read value). Driven directly from registers.
- `PCMSK_write_en` in 1: write strobe for the pin-change mask.
- `PCMSK_data_in` in 8: mask write data.
- `PCMSK_out` out 8: current mask, for bus readback.
- `PCIFR_clear_en` in 1: write strobe for the flag register (write-1-to-clear).
- `PCIFR_clear_data` in 8: bits set to 1 clear the corresponding flags.
- `PCIFR_out` out 8: sticky pin-change flags.
- `PCINT_irq` out 1: equals the OR of all bits of `PCIFR_out`. Combinational from registers only.

## Operation
- Reset (`reset`=1 at a rising edge) clears all of the following to 0:
  - both synchronizer stages `sync1` and `sync2`;
  - `stable` (`PIND_data_out`) and all debounce counters;
  - `PCMSK_out` and `PCIFR_out`.
  - `PCINT_irq` is therefore 0.
- Reset has priority over every other input in the same cycle.
- Synchronizer, per pin: `sync1 <= PIND_pins_in`, then `sync2 <= sync1`. No other logic reads `sync1`.
- Debounce, per pin i, evaluated every edge:
  - If `sync2[i] == stable[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= sync2[i]` and `cnt[i] <= 0`. This is an accept event.
  - Else: `cnt[i] <= cnt[i]+1`.
- A glitch shorter than `DEBOUNCE_CYCLES` mismatching samples returns the counter to 0 and never changes `stable`. Counters never wrap.
- Change detect: an accept event on pin i with `PCMSK_out[i]==1` sets `PCIFR[i]`. Both rising and falling accepted transitions set the flag.
- Flag update, per bit: `PCIFR[i] <= set[i] | (PCIFR[i] & ~(PCIFR_clear_en & PCIFR_clear_data[i]))`. When a set and a clear hit the same bit in the same cycle, the set wins.
- Mask write: `PCMSK <= PCMSK_data_in` when `PCMSK_write_en` is 1. The accept event in the same cycle as a mask write is gated by the old mask value.
- Clearing a mask bit does not clear an already-set flag.
- The post-reset settling transition counts as an accept event, but the mask is 0 after reset, so no flag is set.

## Timing
- Reference point: a pin level stable from before edge E1 onward.
  - `sync1` updates at E1 and `sync2` at E2.
  - The first mismatch count occurs at E3.
  - `stable` (`PIND_data_out`) updates at edge E(2+DEBOUNCE_CYCLES). With the default of 4, that is E6.
- `PCIFR_out` bit and `PCINT_irq` assert at the same edge as the accept event, visible in the following cycle.
- Flag clear: the flag drops at the edge where `PCIFR_clear_en` is sampled. `PCINT_irq` falls in the same cycle if no other flag is set.
- Mask write takes effect at the sampling edge. Readback on `PCMSK_out` is valid the next cycle.
- Reset mid-debounce discards all partial counts. After reset is released, a constant high pin reaches `stable` at E(2+DEBOUNCE_CYCLES) counted from the first non-reset edge.

## Test plan
1. Reset with pins=8'hFF and mask=0. After reset, `PIND_data_out`=8'h00 for 5 edges and 8'hFF at the 6th edge. `PCIFR_out`=0 and `PCINT_irq`=0 throughout.
2. Mask=8'h01, pin0 toggles 0→1 and holds. `PIND_data_out[0]` and `PCIFR_out[0]` rise together at E6. `PCINT_irq`=1 until a clear write with data 8'h01, after which irq=0.
3. Mask=8'h01, pin0 pulses high for 5 clock cycles (4 synchronized mismatches) and 3 clock cycles in separate trials. The 5-clock pulse is accepted. The 3-clock pulse leaves `stable`=0 and `PCIFR`=0.
4. Mask=8'hFF, the accept event on pin3 coincides with `PCIFR_clear_en`=1 and `PCIFR_clear_data`=8'h08. Result: `PCIFR_out`=8'h08 (set wins).
5. An accept event on pin5 in the same cycle as a write of `PCMSK`=8'h20 (old mask 0). Result: `PCIFR_out`=0 and `PCMSK_out`=8'h20. A later 1→0 transition on pin5 sets `PCIFR_out`=8'h20.
6. Assert `reset` one cycle before pin7 would be accepted (`cnt`=3). Result: `stable`, counters, mask, and flags are all 0. The full latency restarts from the release of reset.
